// File: rtl/uart_reg_responder_if.sv
// RX/TX FIFO handshake bundle between the UART core FIFOs and the register responder.
interface uart_reg_responder_if #(
    parameter int DBITS = 8
);
    logic             rx_empty;
    logic [DBITS-1:0] read_data;
    logic             read_uart;
    logic             tx_full;
    logic             write_uart;
    logic [DBITS-1:0] write_data;

    // master = FIFO side, slave = responder
    modport master (
        output rx_empty, read_data, tx_full,
        input  read_uart, write_uart, write_data
    );
    modport slave (
        input  rx_empty, read_data, tx_full,
        output read_uart, write_uart, write_data
    );
endinterface

// File: rtl/uart_reg_responder.sv
// Parses 'W' addr data / 'R' addr commands from the RX FIFO against a small register
// file and pushes exactly one response byte per command into the TX FIFO.
module uart_reg_responder #(
    parameter int DBITS   = 8,
    parameter int NREGS   = 16,
    parameter int TIMEOUT = 1_000_000,
    parameter int TO_BITS = 20
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    uart_reg_responder_if.slave bus,
    output logic [DBITS-1:0]  reg0_out
);
    localparam int               AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [DBITS-1:0] OP_W    = DBITS'(8'h57);
    localparam logic [DBITS-1:0] OP_R    = DBITS'(8'h52);
    localparam logic [DBITS-1:0] RSP_OK  = DBITS'(8'h4B);
    localparam logic [DBITS-1:0] RSP_ERR = DBITS'(8'h3F);
    localparam logic [DBITS:0]   NREGS_W = (DBITS+1)'(NREGS);
    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_EXEC,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic               is_wr_q;
    logic [DBITS-1:0]   addr_q;
    logic [DBITS-1:0]   data_q;
    logic [DBITS-1:0]   resp_q;
    logic [TO_BITS-1:0] to_cnt_q;
    logic [DBITS-1:0]   regs [NREGS];

    logic pop, push, in_get, addr_ok, to_expire;

    assign in_get    = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA);
    // Gated by reset so nothing is popped while the block is held in reset.
    assign pop       = !reset && !bus.rx_empty &&
                       ((state_q == S_IDLE) || in_get);
    assign push      = (state_q == S_RESP) && !bus.tx_full;
    // Full-width compare: 0xFF must not alias onto a valid low address.
    assign addr_ok   = {1'b0, addr_q} < NREGS_W;
    assign to_expire = in_get && bus.rx_empty && (to_cnt_q == TO_LAST);

    assign bus.read_uart  = pop;
    assign bus.write_uart = push;
    assign bus.write_data = resp_q;
    assign reg0_out       = regs[0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    if (bus.read_data == OP_W || bus.read_data == OP_R)
                        state_d = S_GET_ADDR;
                    else
                        state_d = S_RESP;
                end
            end
            S_GET_ADDR: begin
                if (pop)            state_d = is_wr_q ? S_GET_DATA : S_EXEC;
                else if (to_expire) state_d = S_IDLE;
            end
            S_GET_DATA: begin
                if (pop)            state_d = S_EXEC;
                else if (to_expire) state_d = S_IDLE;
            end
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (push) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            is_wr_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            resp_q   <= '0;
            to_cnt_q <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            state_q <= state_d;

            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        is_wr_q <= (bus.read_data == OP_W);
                        if (bus.read_data != OP_W && bus.read_data != OP_R)
                            resp_q <= RSP_ERR;
                    end
                end
                S_GET_ADDR: if (pop) addr_q <= bus.read_data;
                S_GET_DATA: if (pop) data_q <= bus.read_data;
                S_EXEC: begin
                    if (!addr_ok) begin
                        resp_q <= RSP_ERR;
                    end else if (is_wr_q) begin
                        regs[addr_q[AW-1:0]] <= data_q;
                        resp_q               <= RSP_OK;
                    end else begin
                        resp_q <= regs[addr_q[AW-1:0]];
                    end
                end
                default: ;
            endcase

            // Counts consecutive starved cycles inside a partially received command.
            if (pop || !in_get || to_expire)
                to_cnt_q <= '0;
            else
                to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
endmodule
